// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the shift-and-add multiplier.
//  - state_t   : FSM encoding (binary) IDLE -> RUN -> DONE -> IDLE
//  - WIDTH_DEF : default operand width (must match the attached adder)
//  - cnt_width : width of the iteration counter for a given operand width
package mult_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must be able to hold 0..WIDTH inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_shift_reg.sv
// mult_shift_reg: the C/A/Q/M datapath of the shift-and-add multiplier.
//  Ports:
//   clock, reset   rising-edge clock, synchronous active-high clear
//   i_load         capture i_m into M and i_q into Q, clear A and C
//   i_step         perform one iteration: conditional accumulate then shift right
//   i_m, i_q       multiplicand / multiplier to load
//   i_add_s        sum from the external adder (A + M, valid when Q[0]=1)
//   i_add_c_out    final carry from the external adder
//   o_a, o_q, o_m  current register contents (drive the adder inputs)
//   o_next_aq      {A,Q} after the current iteration's shift (used for the product)
module mult_shift_reg
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_m,
  input  logic [WIDTH-1:0]   i_q,
  input  logic [WIDTH-1:0]   i_add_s,
  input  logic               i_add_c_out,
  output logic [WIDTH-1:0]   o_a,
  output logic [WIDTH-1:0]   o_q,
  output logic [WIDTH-1:0]   o_m,
  output logic [2*WIDTH-1:0] o_next_aq
);

  logic             r_c;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;

  logic             w_c;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_next_q;

  // Conditional accumulate followed by a logical right shift of {C,A,Q}.
  // C is cleared on load and refilled with 0 by every shift, so the Q[0]=0
  // branch is equivalent to {1'b0, A}.
  always_comb begin
    w_c   = 1'b0;
    w_sum = {WIDTH{1'b0}};
    if (r_q[0]) begin
      w_c   = i_add_c_out;
      w_sum = i_add_s;
    end else begin
      w_c   = r_c;
      w_sum = r_a;
    end
    w_next_a = {w_c, w_sum[WIDTH-1:1]};
    w_next_q = {w_sum[0], r_q[WIDTH-1:1]};
  end

  // Datapath registers: clear, load operands, iterate, or hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_c <= 1'b0;
      r_a <= {WIDTH{1'b0}};
      r_q <= {WIDTH{1'b0}};
      r_m <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_c <= 1'b0;
      r_a <= {WIDTH{1'b0}};
      r_q <= i_q;
      r_m <= i_m;
    end else if (i_step) begin
      r_c <= 1'b0;
      r_a <= w_next_a;
      r_q <= w_next_q;
    end else begin
      r_c <= r_c;
      r_a <= r_a;
      r_q <= r_q;
      r_m <= r_m;
    end
  end

  assign o_a       = r_a;
  assign o_q       = r_q;
  assign o_m       = r_m;
  assign o_next_aq = {w_next_a, w_next_q};

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned WIDTH x WIDTH multiplier that
// uses an external combinational ripple adder, one add per clock.
//  Ports:
//   clock, reset        rising-edge clock, synchronous active-high clear
//   start               request, sampled only in IDLE
//   a_in, b_in          multiplicand / multiplier, captured on accepted start
//   add_a, add_b        to adder: accumulator A, and M when Q[0]=1 else 0 (0 outside RUN)
//   add_c_in            to adder carry-in, constant 0
//   add_s, add_c_out    from adder: sum and final carry
//   busy                high in RUN and DONE
//   done                one-cycle pulse, product valid
//   product             result, held until the next operation completes
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_c_in,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_c_out,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_done;
  logic                 r_busy;

  logic                 w_load;
  logic                 w_step;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH-1:0]     w_m;
  logic [2*WIDTH-1:0]   w_next_aq;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_RUN);

  mult_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_m         (a_in),
    .i_q         (b_in),
    .i_add_s     (add_s),
    .i_add_c_out (add_c_out),
    .o_a         (w_a),
    .o_q         (w_q),
    .o_m         (w_m),
    .o_next_aq   (w_next_aq)
  );

  // Adder drive is only live during RUN so the adder sees zeros when idle.
  always_comb begin
    add_a    = {WIDTH{1'b0}};
    add_b    = {WIDTH{1'b0}};
    add_c_in = 1'b0;
    if (r_state == S_RUN) begin
      add_a = w_a;
      add_b = w_q[0] ? w_m : {WIDTH{1'b0}};
    end else begin
      add_a = {WIDTH{1'b0}};
      add_b = {WIDTH{1'b0}};
    end
  end

  // Control FSM, iteration counter and registered handshake/product outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= {CW{1'b0}};
      r_product <= {(2*WIDTH){1'b0}};
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_count <= {CW{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_done  <= 1'b0;
          r_count <= r_count + CNT_ONE;
          // Last iteration: capture the post-shift {A,Q} directly.
          if (r_count == LAST_CNT) begin
            r_state   <= S_DONE;
            r_product <= w_next_aq;
            r_done    <= 1'b1;
          end else begin
            r_state   <= S_RUN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier. A behavioural ripple-adder equivalent
// is wired to the add_* ports; expected products (plain a*b) are queued at
// each accepted start and a negedge monitor pops and compares on done.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clock;
  logic           reset;
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_c_in;
  logic [W-1:0]   add_s;
  logic           add_c_out;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_hold;
  logic           prev_done;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c_in  (add_c_in),
    .add_s     (add_s),
    .add_c_out (add_c_out),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Adder attached to the multiplier: plain W-bit add with carry out.
  assign {add_c_out, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c_in};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: product holds between ops, done is one cycle wide, product
  // matches the queued reference on every done.
  always @(negedge clock) begin
    if (!reset) begin
      if (done === 1'b1) begin
        n_done++;
        chk("done_width", int'(prev_done), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_hold = exp_q.pop_front();
          chk("product", int'(product), int'(exp_hold));
        end
      end else begin
        chk("product_hold", int'(product), int'(exp_hold));
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) chk("idle_timeout", 1, 0);
  endtask

  // One full operation with latency and adder-drive checks.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    wait_idle();
    e = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    for (int i = 1; i <= W; i++) begin
      chk("busy_run", int'(busy), 1);
      chk("add_c_in", int'(add_c_in), 0);
      if (b == '0) chk("add_b_zero", int'(add_b), 0);
      // Spot-check random start pulses are ignored mid-operation.
      start = 1'($urandom);
      tick();
      start = 1'b0;
      chk("done_latency", int'(done), (i == W) ? 1 : 0);
    end
    chk("busy_done", int'(busy), 1);
    tick();
    chk("busy_idle", int'(busy), 0);
    chk("done_idle", int'(done), 0);
  endtask

  initial begin
    int d0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    exp_hold = '0;
    prev_done = 1'b0;
    reset    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_product", int'(product), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_add_a", int'(add_a), 0);
    chk("rst_add_b", int'(add_b), 0);
    tick();

    // Directed cases.
    do_op(4'd3, 4'd5);
    chk("p_3x5", int'(product), 8'h0F);
    do_op(4'd15, 4'd15);
    chk("p_15x15", int'(product), 8'hE1);
    do_op(4'd9, 4'd0);
    do_op(4'd0, 4'd11);

    // start held high: accepted every 6 cycles, three operations.
    wait_idle();
    d0    = n_done;
    a_in  = 4'd6;
    b_in  = 4'd7;
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i % 6 == 0) exp_q.push_back(8'd42);
      tick();
    end
    start = 1'b0;
    tick();
    chk("held_done_count", n_done - d0, 3);
    chk("p_6x7", int'(product), 42);

    // Reset during the second RUN cycle aborts the operation.
    wait_idle();
    a_in  = 4'd13;
    b_in  = 4'd13;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset    = 1'b1;
    exp_hold = '0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_product", int'(product), 0);
    reset = 1'b0;
    tick();
    do_op(4'd2, 4'd2);
    chk("p_2x2", int'(product), 4);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(W'(a), W'(b));
      end
    end

    // Random operands with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_op(W'($urandom), W'($urandom));
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
